// File: rtl/ldpc_demuxreg_pkg.sv
// Shared definitions for the LLR demux-register: default widths and a helper
// that sizes the slot address from the slot count.
package ldpc_demuxreg_pkg;

  localparam int LLRWIDTH_DEF = 4;
  localparam int NUMOUTS_DEF  = 4;

  // Smallest address width that can name every slot (at least one bit).
  function automatic int sel_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

  localparam int SELBITS_DEF = sel_bits(NUMOUTS_DEF);

endpackage

// File: rtl/ldpc_demuxreg_slot.sv
// One collect-bank slot: an LLR register with write enable and synchronous
// clear, plus the mask bit recording whether this word has written it.
module ldpc_demuxreg_slot
  import ldpc_demuxreg_pkg::*;
#(
  parameter int LLRWIDTH = LLRWIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                clr,
  input  logic [LLRWIDTH-1:0] d,
  output logic [LLRWIDTH-1:0] q,
  output logic                written
);

  // Clear wins over write: a clear means this word (final beat included) has left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      written <= 1'b0;
    end else if (clr) begin
      q       <= '0;
      written <= 1'b0;
    end else if (we) begin
      q       <= d;
      written <= 1'b1;
    end
  end

endmodule

// File: rtl/ldpc_demuxreg.sv
// LLR demux-register: scatters addressed serial beats into a slot bank and
// hands each assembled word to a registered parallel output via valid/ready.
module ldpc_demuxreg
  import ldpc_demuxreg_pkg::*;
#(
  parameter int LLRWIDTH = LLRWIDTH_DEF,
  parameter int NUMOUTS  = NUMOUTS_DEF,
  parameter int SELBITS  = SELBITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SELBITS-1:0]           sel,
  input  logic [LLRWIDTH-1:0]          din,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUMOUTS*LLRWIDTH-1:0]  dout,
  output logic [NUMOUTS-1:0]           out_mask,
  output logic                         err_sel
);

  localparam logic [SELBITS:0] NUM_SLOTS = (SELBITS+1)'(NUMOUTS);

  logic                        pending;
  logic                        accept;
  logic                        sel_ok;
  logic                        complete;
  logic                        out_free;
  logic                        transfer;
  logic [NUMOUTS-1:0]          slot_we;
  logic [NUMOUTS-1:0]          cmask;
  logic [LLRWIDTH-1:0]         slot_q [NUMOUTS];
  logic [NUMOUTS-1:0]          merged_mask;
  logic [NUMOUTS*LLRWIDTH-1:0] merged_data;

  assign in_ready = !pending;
  assign accept   = in_valid & in_ready;
  assign sel_ok   = {1'b0, sel} < NUM_SLOTS;
  assign out_free = !out_valid | out_ready;
  assign complete = accept & ((&merged_mask) | in_last);
  // While pending no beat is accepted, so the merged view is just the bank.
  assign transfer = (complete | pending) & out_free;

  for (genvar i = 0; i < NUMOUTS; i++) begin : g_slot
    assign slot_we[i] = accept & (sel == SELBITS'(i));

    ldpc_demuxreg_slot #(
      .LLRWIDTH (LLRWIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .we      (slot_we[i]),
      .clr     (transfer),
      .d       (din),
      .q       (slot_q[i]),
      .written (cmask[i])
    );
  end

  // View of the bank as it would look with the current beat folded in.
  always_comb begin
    merged_data = '0;
    merged_mask = cmask;
    for (int i = 0; i < NUMOUTS; i++) begin
      if (slot_we[i]) begin
        merged_data[i*LLRWIDTH +: LLRWIDTH] = din;
        merged_mask[i]                      = 1'b1;
      end else begin
        merged_data[i*LLRWIDTH +: LLRWIDTH] = slot_q[i];
      end
    end
  end

  // A word that completes while the output is occupied parks in the bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else if (transfer) begin
      pending <= 1'b0;
    end else if (complete) begin
      pending <= 1'b1;
    end
  end

  // Output register: load on transfer (replacing a word drained this edge), else drop valid once taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout      <= '0;
      out_mask  <= '0;
      out_valid <= 1'b0;
    end else if (transfer) begin
      dout      <= merged_data;
      out_mask  <= merged_mask;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle flag for an accepted beat addressed past the last slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sel <= 1'b0;
    end else begin
      err_sel <= accept & !sel_ok;
    end
  end

endmodule

// File: tb/tb_ldpc_demuxreg.sv
// Self-checking bench for ldpc_demuxreg: directed scenarios on a 4-slot and a
// 3-slot instance, then randomized traffic scored against a word-level model.
module tb_ldpc_demuxreg;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, in_last, out_valid, out_ready, err_sel;
  logic [1:0]  sel;
  logic [3:0]  din;
  logic [15:0] dout;
  logic [3:0]  out_mask;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_err_sel;
  logic [1:0]  b_sel;
  logic [3:0]  b_din;
  logic [11:0] b_dout;
  logic [2:0]  b_out_mask;

  int tests_run    = 0;
  int tests_failed = 0;

  // word-level reference model for the random run
  bit          model_on = 0;
  logic [3:0]  m_bank [4];
  logic [3:0]  m_mask;
  logic [19:0] exp_q [$];
  bit          rand_running = 0;
  bit          drain = 0;

  ldpc_demuxreg #(.LLRWIDTH(4), .NUMOUTS(4), .SELBITS(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .din(din), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_mask(out_mask), .err_sel(err_sel)
  );

  ldpc_demuxreg #(.LLRWIDTH(4), .NUMOUTS(3), .SELBITS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .sel(b_sel),
    .din(b_din), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .dout(b_dout), .out_mask(b_out_mask), .err_sel(b_err_sel)
  );

  always #5 clk = ~clk;

  task automatic send_a(input logic [1:0] s, input logic [3:0] d, input logic last);
    int wait_cycles;
    in_valid = 1'b1; sel = s; din = d; in_last = last;
    wait_cycles = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      wait_cycles++;
      if (wait_cycles > 200) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL send_a timeout: in_ready stuck at %0b, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    if (model_on) begin
      m_bank[s] = d;
      m_mask[s] = 1'b1;
      if (m_mask == 4'hF || last) begin
        exp_q.push_back({m_mask, m_bank[3], m_bank[2], m_bank[1], m_bank[0]});
        m_mask = '0;
        for (int k = 0; k < 4; k++) m_bank[k] = '0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] s, input logic [3:0] d, input logic last);
    int wait_cycles;
    b_in_valid = 1'b1; b_sel = s; b_din = d; b_in_last = last;
    wait_cycles = 0;
    forever begin
      @(negedge clk);
      if (b_in_ready) break;
      wait_cycles++;
      if (wait_cycles > 200) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL send_b timeout: in_ready stuck at %0b, required 1", b_in_ready);
        b_in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    tests_run++;
    if ({out_valid, dout, out_mask, err_sel, in_ready} !== {1'b0, 16'h0, 4'h0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got v=%0b d=%h m=%h e=%0b r=%0b, required 0/0000/0/0/1",
               out_valid, dout, out_mask, err_sel, in_ready);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    send_a(2'd0, 4'h1, 1'b0);
    send_a(2'd1, 4'h2, 1'b0);
    send_a(2'd2, 4'h3, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_early_valid: got %0b, required 0", out_valid);
    end
    send_a(2'd3, 4'h4, 1'b0);
    tests_run++;
    if ({out_valid, dout, out_mask} !== {1'b1, 16'h4321, 4'hF}) begin
      tests_failed++;
      $display("[TB] FAIL full_word: got v=%0b d=%h m=%h, required 1/4321/f", out_valid, dout, out_mask);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_drained: got out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_last_holes();
    out_ready = 1'b1;
    send_a(2'd2, 4'h5, 1'b0);
    send_a(2'd0, 4'h7, 1'b1);
    tests_run++;
    if ({out_valid, dout, out_mask} !== {1'b1, 16'h0507, 4'b0101}) begin
      tests_failed++;
      $display("[TB] FAIL last_holes: got v=%0b d=%h m=%b, required 1/0507/0101", out_valid, dout, out_mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(2'(i), 4'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++) send_a(2'(i), 4'(i + 10), 1'b0);
    tests_run++;
    if ({in_ready, out_valid, dout} !== {1'b0, 1'b1, 16'h4321}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pending: got r=%0b v=%0b d=%h, required 0/1/4321", in_ready, out_valid, dout);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, out_valid, dout, out_mask} !== {1'b0, 1'b1, 16'h4321, 4'hF}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_hold: got r=%0b v=%0b d=%h m=%h, required 0/1/4321/f",
               in_ready, out_valid, dout, out_mask);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({in_ready, out_valid, dout} !== {1'b1, 1'b1, 16'hDCBA}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_reload: got r=%0b v=%0b d=%h, required 1/1/dcba", in_ready, out_valid, dout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rewrite();
    out_ready = 1'b1;
    send_a(2'd1, 4'h3, 1'b0);
    send_a(2'd1, 4'h9, 1'b0);
    send_a(2'd0, 4'h1, 1'b0);
    send_a(2'd2, 4'h2, 1'b0);
    send_a(2'd3, 4'h4, 1'b0);
    tests_run++;
    if ({out_valid, dout, out_mask, err_sel} !== {1'b1, 16'h4291, 4'hF, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL rewrite: got v=%0b d=%h m=%h e=%0b, required 1/4291/f/0",
               out_valid, dout, out_mask, err_sel);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_sel();
    b_out_ready = 1'b1;
    send_b(2'd0, 4'h5, 1'b0);
    send_b(2'd3, 4'h7, 1'b0);
    tests_run++;
    if ({b_err_sel, b_out_valid} !== {1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL bad_sel_pulse: got e=%0b v=%0b, required 1/0", b_err_sel, b_out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (b_err_sel !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bad_sel_width: got err_sel=%0b, required 0", b_err_sel);
    end
    send_b(2'd1, 4'h6, 1'b0);
    send_b(2'd2, 4'h8, 1'b0);
    tests_run++;
    if ({b_out_valid, b_dout, b_out_mask} !== {1'b1, 12'h865, 3'b111}) begin
      tests_failed++;
      $display("[TB] FAIL bad_sel_word: got v=%0b d=%h m=%b, required 1/865/111", b_out_valid, b_dout, b_out_mask);
    end
    send_b(2'd3, 4'h1, 1'b1);
    tests_run++;
    if ({b_err_sel, b_out_valid, b_dout, b_out_mask} !== {1'b1, 1'b1, 12'h000, 3'b000}) begin
      tests_failed++;
      $display("[TB] FAIL empty_word: got e=%0b v=%0b d=%h m=%b, required 1/1/000/000",
               b_err_sel, b_out_valid, b_dout, b_out_mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_pending();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(2'(i), 4'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++) send_a(2'(i), 4'(i + 2), 1'b0);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_setup_pending: got in_ready=%0b, required 0", in_ready);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, dout, out_mask, err_sel, in_ready} !== {1'b0, 16'h0, 4'h0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid: got v=%0b d=%h m=%h e=%0b r=%0b, required 0/0000/0/0/1",
               out_valid, dout, out_mask, err_sel, in_ready);
    end
    @(negedge clk); rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_no_stale: got out_valid=%0b, required 0", out_valid);
    end
    for (int i = 0; i < 4; i++) send_a(2'(i), 4'(i + 5), 1'b0);
    tests_run++;
    if ({out_valid, dout, out_mask} !== {1'b1, 16'h8765, 4'hF}) begin
      tests_failed++;
      $display("[TB] FAIL rst_fresh: got v=%0b d=%h m=%h, required 1/8765/f", out_valid, dout, out_mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    exp_q.delete();
    m_mask = '0;
    for (int k = 0; k < 4; k++) m_bank[k] = '0;
    model_on = 1; rand_running = 1; drain = 0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send_a(2'($urandom_range(0, 3)), 4'($urandom), ($urandom_range(0, 7) == 0));
        end
        drain = 1;
        repeat (20) @(posedge clk);
        #1;
        rand_running = 0;
      end
      begin
        while (rand_running) begin
          out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      begin
        while (rand_running) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
              tests_failed++;
              $display("[TB] FAIL rand_extra: got word m=%h d=%h, required none", out_mask, dout);
            end else if ({out_mask, dout} !== exp_q[0]) begin
              tests_failed++;
              $display("[TB] FAIL rand_word: got m=%h d=%h, required m=%h d=%h",
                       out_mask, dout, exp_q[0][19:16], exp_q[0][15:0]);
              void'(exp_q.pop_front());
            end else begin
              void'(exp_q.pop_front());
            end
          end
        end
      end
    join
    model_on = 0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL rand_missing: got %0d words undelivered, required 0", exp_q.size());
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0;
    in_valid = 1'b0; sel = '0; din = '0; in_last = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_sel = '0; b_din = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    test_reset();
    test_full_word();
    test_last_holes();
    test_back_to_back();
    test_rewrite();
    test_bad_sel();
    test_reset_pending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
